// File: rtl/gcd_pkg.sv
// ---------------------------------------------------------------------------
// gcd_pkg
//   Shared definitions for the round-robin GCD scheduler slice.
//   - state_e       : FSM states of the shared GCD engine
//   - NREQ_DEFAULT  : default number of requester ports
//   - WIDTH_DEFAULT : default operand/result width
//   - idw()         : requester-ID width for a given port count
// ---------------------------------------------------------------------------
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NREQ_DEFAULT  = 4;
  localparam int WIDTH_DEFAULT = 16;

  // Keep the ID at least one bit wide so a port vector is always legal.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_rr_arbiter.sv
// ---------------------------------------------------------------------------
// gcd_rr_arbiter
//   Combinational rotate-priority pick. Searches rr_ptr_i+1, rr_ptr_i+2, ...
//   (mod NREQ) and returns the first requester with a pending job.
//   Ports:
//     req_valid_i : per-requester pending flags
//     rr_ptr_i    : index of the most recently granted requester
//     grant_o     : index of the selected requester (0 when none valid)
//     any_valid_o : at least one requester is pending
// ---------------------------------------------------------------------------
module gcd_rr_arbiter
  import gcd_pkg::*;
#(
  parameter  int NREQ = NREQ_DEFAULT,
  localparam int IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IDW-1:0]  rr_ptr_i,
  output logic [IDW-1:0]  grant_o,
  output logic            any_valid_o
);

  // Walk the search order from farthest to nearest so the nearest pending
  // requester after the pointer is the last (and therefore winning) write.
  always_comb begin
    logic [IDW-1:0] idx;
    idx         = '0;
    grant_o     = '0;
    any_valid_o = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(rr_ptr_i) + k) % NREQ);
      if (req_valid_i[idx]) begin
        grant_o     = idx;
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_rr_scheduler.sv
// ---------------------------------------------------------------------------
// gcd_rr_scheduler
//   One iterative subtract-and-compare GCD engine shared round-robin among
//   NREQ requesters. One job in flight; valid/ready on every port.
//   Ports:
//     clk_i, rst_i   : clock, synchronous active-high reset
//     req_valid_i    : requester i has a job pending
//     req_a_i/req_b_i: operands, requester i at [i*WIDTH +: WIDTH]
//     req_ready_o    : one-hot grant, only in IDLE
//     rsp_valid_o    : result available (held until rsp_ready_i)
//     rsp_ready_i    : consumer accepts result
//     rsp_id_o       : requester that owns the result
//     rsp_gcd_o      : GCD result
//     rsp_err_o      : both operands were zero
//     busy_o         : engine not idle
// ---------------------------------------------------------------------------
module gcd_rr_scheduler
  import gcd_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEFAULT,
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int IDW   = idw(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IDW-1:0]        rsp_id_o,
  output logic [WIDTH-1:0]      rsp_gcd_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] gcd_q;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic             valid_q;
  logic             err_q;

  logic [IDW-1:0]   grant_idx;
  logic             any_valid;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  gcd_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arbiter (
    .req_valid_i (req_valid_i),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant_idx),
    .any_valid_o (any_valid)
  );

  // A job is taken only while idle and never during the reset cycle.
  assign accept = (state_q == IDLE) && any_valid && !rst_i;

  // Operand mux for the granted requester and the one-hot ready vector.
  always_comb begin
    req_ready_o = '0;
    sel_a       = '0;
    sel_b       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a          = req_a_i[i*WIDTH +: WIDTH];
        sel_b          = req_b_i[i*WIDTH +: WIDTH];
        req_ready_o[i] = accept;
      end
    end
  end

  // Engine FSM: load on accept, one compare-or-subtract step per RUN cycle,
  // hold the result in DONE until the consumer takes it. Zero operands skip
  // RUN entirely since gcd(x,0) = x and the loop would never converge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      gcd_q    <= '0;
      id_q     <= '0;
      rr_ptr_q <= IDW'(NREQ - 1);
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q      <= sel_a;
            b_q      <= sel_b;
            id_q     <= grant_idx;
            rr_ptr_q <= grant_idx;
            if ((sel_a == '0) || (sel_b == '0)) begin
              gcd_q   <= sel_a | sel_b;
              err_q   <= (sel_a == '0) && (sel_b == '0);
              valid_q <= 1'b1;
              state_q <= DONE;
            end else begin
              err_q   <= 1'b0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (a_q == b_q) begin
            gcd_q   <= a_q;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else if (a_q > b_q) begin
            a_q <= a_q - b_q;
          end else begin
            b_q <= b_q - a_q;
          end
        end
        DONE: begin
          if (rsp_ready_i) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_o = valid_q;
  assign rsp_id_o    = id_q;
  assign rsp_gcd_o   = gcd_q;
  assign rsp_err_o   = err_q;
  assign busy_o      = (state_q != IDLE);

endmodule
